// File: rtl/sha_msg_schedule_pkg.sv
// Shared SHA-256 definitions: word/block widths, hash-state type,
// round constants and the message-schedule small-sigma helpers.
package sha_msg_schedule_pkg;

    localparam int SHA_WORD_W  = 32;
    localparam int SHA_BLOCK_W = 512;

    typedef struct packed {
        logic [SHA_WORD_W-1:0] a;
        logic [SHA_WORD_W-1:0] b;
        logic [SHA_WORD_W-1:0] c;
        logic [SHA_WORD_W-1:0] d;
        logic [SHA_WORD_W-1:0] e;
        logic [SHA_WORD_W-1:0] f;
        logic [SHA_WORD_W-1:0] g;
        logic [SHA_WORD_W-1:0] h;
    } HashState;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    localparam logic [SHA_WORD_W-1:0] SHA256_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // sigma0 = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [SHA_WORD_W-1:0] small_sigma0(input logic [SHA_WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // sigma1 = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [SHA_WORD_W-1:0] small_sigma1(input logic [SHA_WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha_msg_expand.sv
// Combinational message-expansion step: produces the next schedule word
// from four taps of the 16-word sliding window (t-2, t-7, t-15, t-16).
module sha_msg_expand
    import sha_msg_schedule_pkg::*;
(
    input  logic [SHA_WORD_W-1:0] w14_i,
    input  logic [SHA_WORD_W-1:0] w9_i,
    input  logic [SHA_WORD_W-1:0] w1_i,
    input  logic [SHA_WORD_W-1:0] w0_i,
    output logic [SHA_WORD_W-1:0] new_word_o
);

    // Modulo-2^32 sum; carries out of bit 31 are simply dropped.
    always_comb begin
        new_word_o = small_sigma1(w14_i) + w9_i + small_sigma0(w1_i) + w0_i;
    end

endmodule

// File: rtl/sha_msg_schedule.sv
// SHA-256 message scheduler: takes one 512-bit block and streams
// W[0..NUM_ROUNDS-1] over a valid/ready interface, one word per handshake.
// Optional macro SHA_SCHED_KOUT_EN adds the k_word output (round constant
// K[w_idx], registered alongside w_word).
module sha_msg_schedule
    import sha_msg_schedule_pkg::*;
#(
    parameter int NUM_ROUNDS = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   blk_valid,
    output logic                   blk_ready,
    input  logic [SHA_BLOCK_W-1:0] blk_data,
    input  logic                   abort,
    output logic                   w_valid,
    input  logic                   w_ready,
    output logic [SHA_WORD_W-1:0]  w_word,
    output logic [5:0]             w_idx,
    output logic                   w_last
`ifdef SHA_SCHED_KOUT_EN
    ,
    output logic [SHA_WORD_W-1:0]  k_word
`endif
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

    sched_state_e          state_q, state_d;
    logic [5:0]            t_q, t_d;
    logic [SHA_WORD_W-1:0] window_q  [16];
    logic [SHA_WORD_W-1:0] window_d  [16];
    logic [SHA_WORD_W-1:0] load_word [16];
    logic [SHA_WORD_W-1:0] shift_in  [16];
    logic [SHA_WORD_W-1:0] new_word;
    logic                  run;
    logic                  is_last;
    logic                  blk_fire;
    logic                  w_fire;

    assign run      = (state_q == ST_RUN);
    assign is_last  = (t_q == LAST_IDX);
    // abort outranks both handshakes: it masks block acceptance in IDLE
    // and voids a word handshake in RUN.
    assign blk_fire = !run && blk_valid && !abort;
    assign w_fire   = run && w_ready && !abort;

    // Per-word load source (big-endian word order) and shift source.
    for (genvar gi = 0; gi < 16; gi++) begin : g_window_src
        assign load_word[gi] = blk_data[SHA_BLOCK_W-1-SHA_WORD_W*gi -: SHA_WORD_W];
        if (gi < 15) begin : g_shift
            assign shift_in[gi] = window_q[gi+1];
        end else begin : g_tail
            assign shift_in[gi] = new_word;
        end
    end

    sha_msg_expand u_expand (
        .w14_i      (window_q[14]),
        .w9_i       (window_q[9]),
        .w1_i       (window_q[1]),
        .w0_i       (window_q[0]),
        .new_word_o (new_word)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: load in IDLE, leave RUN on last word or abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (blk_fire) state_d = ST_RUN;
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (w_fire && is_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode; word outputs are forced to zero outside RUN.
    always_comb begin
        blk_ready = !run && !abort;
        w_valid   = run;
        w_word    = run ? window_q[0] : '0;
        w_idx     = run ? t_q : '0;
        w_last    = run && is_last;
    end

    // Window next-state: parallel load on block accept, shift on word accept.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            window_d[i] = window_q[i];
            if (blk_fire) begin
                window_d[i] = load_word[i];
            end else if (w_fire) begin
                window_d[i] = shift_in[i];
            end
        end
    end

    // Round-index next-state; restarts at zero on load, completion or abort.
    always_comb begin
        t_d = t_q;
        if (blk_fire || (run && abort)) begin
            t_d = '0;
        end else if (w_fire) begin
            t_d = is_last ? 6'd0 : t_q + 6'd1;
        end
    end

    // Window and round-index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                window_q[i] <= '0;
            end
            t_q <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                window_q[i] <= window_d[i];
            end
            t_q <= t_d;
        end
    end

`ifdef SHA_SCHED_KOUT_EN
    logic [SHA_WORD_W-1:0] k_q, k_d;

    // Round constant tracks the index that t will hold after this edge.
    always_comb begin
        k_d = k_q;
        if (blk_fire) begin
            k_d = SHA256_K[0];
        end else if (w_fire) begin
            k_d = SHA256_K[t_q + 6'd1];
        end
    end

    // Round-constant register, updated on the same edges as the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

    assign k_word = run ? k_q : '0;
`endif

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Self-checking bench for sha_msg_schedule: every block's schedule is
// recomputed with the textbook W[t] recurrence and compared word by word.
module tb_sha_msg_schedule;

    localparam int NR = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [511:0] blk_data = '0;
    logic         abort = 1'b0;
    logic         w_valid;
    logic         w_ready = 1'b0;
    logic [31:0]  w_word;
    logic [5:0]   w_idx;
    logic         w_last;
`ifdef SHA_SCHED_KOUT_EN
    logic [31:0]  k_word;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] captured [64];

    always #5 clk = ~clk;

    sha_msg_schedule #(.NUM_ROUNDS(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .abort     (abort),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_word    (w_word),
        .w_idx     (w_idx),
        .w_last    (w_last)
`ifdef SHA_SCHED_KOUT_EN
        ,
        .k_word    (k_word)
`endif
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [511:0] abc_block();
        logic [511:0] b;
        b = '0;
        b[511:480] = 32'h61626380;
        b[31:0]    = 32'h00000018;
        return b;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom;
        return b;
    endfunction

    // Push one block and consume its schedule. stall_pct: chance (0..99) of
    // w_ready=0 per cycle. abort_at / reset_at: index at which to abort or
    // pulse rst_n (-1 = never).
    task automatic run_block(input string name, input logic [511:0] blk,
                             input int stall_pct, input int abort_at, input int reset_at);
        logic [31:0] w [64];
        int t;
        int cyc;
        int words;
        bit done;
        logic rdy;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) w[i] = ref_s1(w[i-2]) + w[i-7] + ref_s0(w[i-15]) + w[i-16];

        @(negedge clk);
        cyc = 0;
        while (blk_ready !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (blk_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s blk_ready_wait: got %b want 1", name, blk_ready);
        end
        blk_valid = 1'b1;
        blk_data  = blk;
        w_ready   = 1'b0;
        @(negedge clk);
        blk_valid = 1'b0;
        blk_data  = rand_block();

        t = 0; cyc = 0; words = 0; done = 0;
        while (!done) begin
            checks++;
            if (w_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s w_valid t=%0d: got %b want 1", name, t, w_valid);
            end
            checks++;
            if (w_idx !== 6'(t)) begin
                errors++;
                $display("FAIL %s w_idx: got %0d want %0d", name, w_idx, t);
            end
            checks++;
            if (w_word !== w[t]) begin
                errors++;
                $display("FAIL %s w_word t=%0d: got %h want %h", name, t, w_word, w[t]);
            end
            captured[t] = w_word;
            checks++;
            if (w_last !== (t == NR - 1)) begin
                errors++;
                $display("FAIL %s w_last t=%0d: got %b want %b", name, t, w_last, (t == NR - 1));
            end
            checks++;
            if (blk_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s blk_ready_run t=%0d: got %b want 0", name, t, blk_ready);
            end
`ifdef SHA_SCHED_KOUT_EN
            if (t == 0 || t == 1 || t == 63) begin
                logic [31:0] kexp;
                kexp = (t == 0) ? 32'h428a2f98 : (t == 1) ? 32'h71374491 : 32'hc67178f2;
                checks++;
                if (k_word !== kexp) begin
                    errors++;
                    $display("FAIL %s k_word t=%0d: got %h want %h", name, t, k_word, kexp);
                end
            end
`endif
            rdy = ($urandom_range(99) >= stall_pct);
            if (t == abort_at || t == reset_at) rdy = 1'b1;
            w_ready = rdy;

            if (t == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort   = 1'b0;
                w_ready = 1'b0;
                #1;
                checks++;
                if (w_valid !== 1'b0 || blk_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s abort_flush: got valid=%b ready=%b want valid=0 ready=1",
                             name, w_valid, blk_ready);
                end
                done = 1;
            end else if (t == reset_at) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                checks++;
                if (w_valid !== 1'b0 || w_word !== 32'h0 || w_idx !== 6'h0 ||
                    w_last !== 1'b0 || blk_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s async_reset: got valid=%b word=%h idx=%0d last=%b ready=%b want 0/0/0/0/1",
                             name, w_valid, w_word, w_idx, w_last, blk_ready);
                end
`ifdef SHA_SCHED_KOUT_EN
                checks++;
                if (k_word !== 32'h0) begin
                    errors++;
                    $display("FAIL %s async_reset_k: got %h want 0", name, k_word);
                end
`endif
                #1 rst_n = 1'b1;
                w_ready = 1'b0;
                done = 1;
            end else begin
                @(negedge clk);
                cyc++;
                if (rdy) begin
                    words++;
                    if (t == NR - 1) begin
                        checks++;
                        if (w_valid !== 1'b0 || blk_ready !== 1'b1) begin
                            errors++;
                            $display("FAIL %s end_idle: got valid=%b ready=%b want valid=0 ready=1",
                                     name, w_valid, blk_ready);
                        end
                        done = 1;
                    end else begin
                        t++;
                    end
                end
                if (!done && cyc > 2000) begin
                    errors++;
                    checks++;
                    $display("FAIL %s timeout: got t=%0d want %0d", name, t, NR - 1);
                    done = 1;
                end
            end
        end
        w_ready = 1'b0;
        $display("block %s: words=%0d stall_pct=%0d abort_at=%0d reset_at=%0d errors=%0d",
                 name, words, stall_pct, abort_at, reset_at, errors);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (blk_ready !== 1'b1 || w_valid !== 1'b0 || w_word !== 32'h0 ||
            w_idx !== 6'h0 || w_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b valid=%b word=%h idx=%0d last=%b want 1/0/0/0/0",
                     blk_ready, w_valid, w_word, w_idx, w_last);
        end
`ifdef SHA_SCHED_KOUT_EN
        checks++;
        if (k_word !== 32'h0) begin
            errors++;
            $display("FAIL reset_k: got %h want 0", k_word);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_abc();
        run_block("abc", abc_block(), 0, -1, -1);
        checks++;
        if (captured[0] !== 32'h61626380 || captured[15] !== 32'h00000018) begin
            errors++;
            $display("FAIL abc_w0_w15: got %h %h want 61626380 00000018", captured[0], captured[15]);
        end
        checks++;
        if (captured[16] !== 32'h61626380 || captured[17] !== 32'h000F0000) begin
            errors++;
            $display("FAIL abc_w16_w17: got %h %h want 61626380 000f0000", captured[16], captured[17]);
        end
    endtask

    task automatic test_stall();
        run_block("abc_stall", abc_block(), 45, -1, -1);
    endtask

    task automatic test_abort();
        run_block("abort20", rand_block(), 20, 20, -1);
        run_block("after_abort", abc_block(), 0, -1, -1);
    endtask

    task automatic test_abort_idle();
        @(negedge clk);
        blk_valid = 1'b1;
        blk_data  = abc_block();
        abort     = 1'b1;
        #1;
        checks++;
        if (blk_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_mask: got blk_ready=%b want 0", blk_ready);
        end
        @(negedge clk);
        blk_valid = 1'b0;
        abort     = 1'b0;
        checks++;
        if (w_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_noload: got w_valid=%b want 0", w_valid);
        end
        $display("abort in idle: block refused");
    endtask

    task automatic test_async_reset();
        run_block("reset40", rand_block(), 10, -1, 40);
        run_block("after_reset", abc_block(), 30, -1, -1);
    endtask

    task automatic test_all_ones();
        logic [511:0] b;
        b = '1;
        run_block("all_ones", b, 25, -1, -1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) run_block($sformatf("rand%0d", i), rand_block(), 30, -1, -1);
    endtask

    initial begin
        test_reset();
        test_abc();
        test_stall();
        test_abort();
        test_abort_idle();
        test_async_reset();
        test_all_ones();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
